// File: rtl/jogo_pkg.sv
// Shared types for the ultimate tic-tac-toe game core: cell/board codes, FSM
// states, the eight winning lines and one-hot decoding.
package jogo_pkg;

  typedef enum logic [1:0] {
    VAZIO = 2'b00,
    X     = 2'b01,
    O     = 2'b10,
    VELHA = 2'b11
  } codigo_t;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    VERIFICA     = 4'd1,
    GRAVA        = 4'd2,
    AVALIA_MICRO = 4'd3,
    AVALIA_MACRO = 4'd4,
    FIM          = 4'd5,
    REJEITA      = 4'd6
  } estado_t;

  // Rows, columns, then the two diagonals of a row-major 3x3 board
  localparam logic [3:0] LINHAS [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  typedef struct packed {
    logic       valido;
    logic [3:0] idx;
  } indice_t;

  // Index is forced to 0 when the vector is not exactly one-hot so it is
  // always safe to use as an array index.
  function automatic indice_t onehot_idx(input logic [8:0] v);
    indice_t r;
    int      n;
    r = '0;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) begin
        n++;
        r.idx = 4'(i);
      end
    end
    r.valido = (n == 1);
    if (!r.valido) r.idx = '0;
    return r;
  endfunction

endpackage

// File: rtl/tabuleiro_jogo_if.sv
// Play request / game status bundle between the play-capture circuit and
// the game-state keeper.
interface tabuleiro_jogo_if;
  logic        jogar;
  logic [8:0]  macro;
  logic [8:0]  micro;
  logic        pronto;
  logic        jogada_ok;
  logic        ocupado;
  logic        jogador;
  logic        macro_livre;
  logic [8:0]  macro_proximo;
  logic [17:0] estado_macro;
  logic        fim_jogo;
  logic [1:0]  vencedor;
  logic [3:0]  db_estado;

  modport master (
    output jogar, macro, micro,
    input  pronto, jogada_ok, ocupado, jogador, macro_livre, macro_proximo,
           estado_macro, fim_jogo, vencedor, db_estado
  );

  modport slave (
    input  jogar, macro, micro,
    output pronto, jogada_ok, ocupado, jogador, macro_livre, macro_proximo,
           estado_macro, fim_jogo, vencedor, db_estado
  );
endinterface

// File: rtl/avalia_tabuleiro.sv
// Combinational 3x3 evaluator: winner code, 11 when no open cell is left
// and nobody has a line, 00 otherwise. Cells at 11 never form a line.
module avalia_tabuleiro import jogo_pkg::*; (
  input  logic [8:0][1:0] tab,
  output logic [1:0]      resultado
);
  logic       cheio;
  logic [1:0] a, b, c;

  always_comb begin
    resultado = VAZIO;
    cheio     = 1'b1;
    a = '0;
    b = '0;
    c = '0;
    for (int i = 0; i < 9; i++)
      if (tab[i] == VAZIO) cheio = 1'b0;
    for (int l = 0; l < 8; l++) begin
      a = tab[LINHAS[l][0]];
      b = tab[LINHAS[l][1]];
      c = tab[LINHAS[l][2]];
      if (a != VAZIO && a != VELHA && a == b && a == c) resultado = a;
    end
    if (resultado == VAZIO && cheio) resultado = VELHA;
  end
endmodule

// File: rtl/tabuleiro_jogo.sv
// Game-state keeper: validates captured plays, stores the 81-cell board,
// resolves micro/macro boards and tracks turn, forced board and game end.
module tabuleiro_jogo import jogo_pkg::*; (
  input  logic             clock,
  input  logic             reset,
  tabuleiro_jogo_if.slave  bus
);
  estado_t          st, st_prox;
  logic [8:0]       macro_oh, micro_oh;
  logic [80:0][1:0] celulas;
  logic [8:0][1:0]  estado_macro;
  logic [8:0][1:0]  tab_micro;
  logic [1:0]       res_micro, res_macro;
  logic             jogador, macro_livre, fim_jogo;
  logic [8:0]       macro_proximo;
  logic [1:0]       vencedor;
  indice_t          mi, ui;
  logic [6:0]       base, ci;
  logic             rejeita;

  assign mi   = onehot_idx(macro_oh);
  assign ui   = onehot_idx(micro_oh);
  assign base = 7'(mi.idx) * 7'd9;
  assign ci   = base + 7'(ui.idx);

  assign rejeita = fim_jogo || !mi.valido || !ui.valido
                || (estado_macro[mi.idx] != VAZIO)
                || (!macro_livre && macro_oh != macro_proximo)
                || (celulas[ci] != VAZIO);

  always_comb begin
    tab_micro = '0;
    for (int i = 0; i < 9; i++) tab_micro[i] = celulas[base + 7'(i)];
  end

  avalia_tabuleiro u_micro (.tab(tab_micro),    .resultado(res_micro));
  avalia_tabuleiro u_macro (.tab(estado_macro), .resultado(res_macro));

  always_ff @(posedge clock) begin
    if (reset) st <= OCIOSO;
    else       st <= st_prox;
  end

  always_comb begin
    st_prox = st;
    case (st)
      OCIOSO:       if (bus.jogar) st_prox = VERIFICA;
      VERIFICA:     st_prox = rejeita ? REJEITA : GRAVA;
      GRAVA:        st_prox = AVALIA_MICRO;
      AVALIA_MICRO: st_prox = AVALIA_MACRO;
      AVALIA_MACRO: st_prox = FIM;
      FIM:          st_prox = OCIOSO;
      REJEITA:      st_prox = OCIOSO;
      default:      st_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      macro_oh      <= '0;
      micro_oh      <= '0;
      celulas       <= '0;
      estado_macro  <= '0;
      jogador       <= 1'b0;
      macro_livre   <= 1'b1;
      macro_proximo <= '0;
      fim_jogo      <= 1'b0;
      vencedor      <= '0;
    end else begin
      case (st)
        OCIOSO: if (bus.jogar) begin
          macro_oh <= bus.macro;
          micro_oh <= bus.micro;
        end
        // Player code is 01 for X (jogador=0) and 10 for O (jogador=1)
        GRAVA:        celulas[ci] <= {jogador, ~jogador};
        AVALIA_MICRO: estado_macro[mi.idx] <= res_micro;
        AVALIA_MACRO: begin
          if (res_macro != VAZIO) begin
            fim_jogo <= 1'b1;
            vencedor <= res_macro;
          end
          jogador <= ~jogador;
          if (estado_macro[ui.idx] == VAZIO) begin
            macro_livre   <= 1'b0;
            macro_proximo <= micro_oh;
          end else begin
            macro_livre   <= 1'b1;
            macro_proximo <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pronto        = (st == FIM) || (st == REJEITA);
  assign bus.jogada_ok     = (st == FIM);
  assign bus.ocupado       = (st != OCIOSO);
  assign bus.jogador       = jogador;
  assign bus.macro_livre   = macro_livre;
  assign bus.macro_proximo = macro_proximo;
  assign bus.estado_macro  = estado_macro;
  assign bus.fim_jogo      = fim_jogo;
  assign bus.vencedor      = vencedor;
  assign bus.db_estado     = st;
endmodule
